q_max_scanner: RTL and testbench

//   Scans the Q-table row for one board state and returns the largest Q-value

---
 rtl/q_max_scanner.sv | 136 +++++++++++++
 tb/tb_q_max_scanner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/q_max_scanner.sv
// q_max_scanner: streams one Q-table row over a sync-read port and
// returns the largest legal Q-value and its action index.
module q_max_scanner #(
  parameter int DATA_W    = 16,
  parameter int N_ACTIONS = 9,
  parameter int ADDR_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_ACTIONS-1:0] legal_mask,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_W-1:0]    max_q,
  output logic [ADDR_W-1:0]    best_action,
  output logic                 no_legal
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_ACTIONS - 1);

  state_t state, state_nxt;

  logic [N_ACTIONS-1:0]     mask_q;
  logic                     cmp_vld;
  logic [ADDR_W-1:0]        cmp_idx;
  logic signed [DATA_W-1:0] best_q;
  logic [ADDR_W-1:0]        best_idx;
  logic                     best_vld;
  logic                     last_cmp;
  logic                     take;

  assign last_cmp = cmp_vld && (cmp_idx == LAST);

  // A legal entry loads when nothing is held yet, else only on strict gain
  assign take = cmp_vld && mask_q[cmp_idx] &&
                (!best_vld || ($signed(rd_data) > best_q));

  // Next-state: read sweep, wait for last compare, one result cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (rd_addr == LAST) state_nxt = DRAIN;
      DRAIN:   if (last_cmp) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Read address generator, handshake flags and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mask_q      <= '0;
      max_q       <= '0;
      best_action <= '0;
      no_legal    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mask_q  <= legal_mask;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
        end
        READ: begin
          if (rd_addr == LAST) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        DRAIN: ;
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          if (best_vld) begin
            max_q       <= best_q;
            best_action <= best_idx;
            no_legal    <= 1'b0;
          end else begin
            max_q       <= '0;
            best_action <= '0;
            no_legal    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Compare stage: tracks which address the returning rd_data belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_vld  <= 1'b0;
      cmp_idx  <= '0;
      best_q   <= '0;
      best_idx <= '0;
      best_vld <= 1'b0;
    end else begin
      cmp_vld <= rd_en;
      cmp_idx <= rd_addr;
      if (state == IDLE && start) begin
        best_vld <= 1'b0;
      end else if (take) begin
        best_q   <= $signed(rd_data);
        best_idx <= cmp_idx;
        best_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_q_max_scanner.sv
// tb_q_max_scanner: directed vectors against a behavioural
// synchronous-read Q-row memory.
module tb_q_max_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  legal_mask;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic [15:0] max_q;
  logic [3:0]  best_action;
  logic        no_legal;

  logic signed [15:0] row [9];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  q_max_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .legal_mask  (legal_mask),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .max_q       (max_q),
    .best_action (best_action),
    .no_legal    (no_legal)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      if (rd_addr < 4'd9) rd_data <= row[rd_addr];
      else                rd_data <= 16'hDEAD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input string tag, input logic [8:0] mask,
                          input logic [15:0] exp_q,
                          input logic [3:0] exp_idx,
                          input logic exp_nl, input bit pulse_again);
    int n_done;
    int done_at;
    int nrd;
    int addr_err;
    n_done   = 0;
    done_at  = -1;
    nrd      = 0;
    addr_err = 0;
    @(negedge clk);
    start      = 1'b1;
    legal_mask = mask;
    @(posedge clk);
    #1;
    start      = 1'b0;
    legal_mask = 9'h000;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int n = 0; n < 16; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (rd_en) begin
        if (int'(rd_addr) != nrd) addr_err++;
        nrd++;
      end
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = n;
      end
      if (pulse_again && n == 2) begin
        start      = 1'b1;
        legal_mask = 9'h000;
      end
      if (n == 3) start = 1'b0;
    end
    chk({tag, "_done_at"}, done_at, 32'd11);
    chk({tag, "_ndone"}, n_done, 32'd1);
    chk({tag, "_nreads"}, nrd, 32'd9);
    chk({tag, "_addr_seq"}, addr_err, 32'd0);
    chk({tag, "_max_q"}, {16'd0, max_q}, {16'd0, exp_q});
    chk({tag, "_best"}, {28'd0, best_action}, {28'd0, exp_idx});
    chk({tag, "_no_legal"}, {31'd0, no_legal}, {31'd0, exp_nl});
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int seen_done;
    rst_n      = 1'b0;
    start      = 1'b0;
    legal_mask = 9'h000;
    row = '{16'sd10, -16'sd3, 16'sd25, 16'sd7, 16'sd25,
            16'sd0, -16'sd1, 16'sd4, 16'sd2};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_no_legal", {31'd0, no_legal}, 32'd0);
    chk("rst_max_q", {16'd0, max_q}, 32'd0);
    chk("rst_best", {28'd0, best_action}, 32'd0);
    chk("rst_rd_addr", {28'd0, rd_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_scan("t1_full", 9'h1FF, 16'd25, 4'd2, 1'b0, 1'b0);
    run_scan("t2_mask", 9'h1FB, 16'd25, 4'd4, 1'b0, 1'b0);

    row = '{-16'sd5, -16'sd2, -16'sd9, -16'sd4, -16'sd3,
            -16'sd8, -16'sd6, -16'sd2, -16'sd7};
    run_scan("t3_neg", 9'h1FF, 16'hFFFE, 4'd1, 1'b0, 1'b0);

    row = '{-16'sd32768, 16'sd3, 16'sd32767, -16'sd1, 16'sd0,
            16'sd100, -16'sd100, 16'sd1, 16'sd2};
    run_scan("t3_ext", 9'h1FF, 16'h7FFF, 4'd2, 1'b0, 1'b0);
    run_scan("t3_min", 9'h001, 16'h8000, 4'd0, 1'b0, 1'b0);
    run_scan("t3_min_last", 9'h101, 16'h0002, 4'd8, 1'b0, 1'b0);

    run_scan("t4_none", 9'h000, 16'd0, 4'd0, 1'b1, 1'b0);

    row = '{16'sd10, -16'sd3, 16'sd25, 16'sd7, 16'sd25,
            16'sd0, -16'sd1, 16'sd4, 16'sd2};
    run_scan("t5_restart", 9'h1FF, 16'd25, 4'd2, 1'b0, 1'b1);

    @(negedge clk);
    start      = 1'b1;
    legal_mask = 9'h1FF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rd_en", {31'd0, rd_en}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_max_q", {16'd0, max_q}, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    chk("t6_no_done", seen_done, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done++;
    end
    chk("t6_quiet", seen_done, 32'd0);
    run_scan("t6_after", 9'h1FB, 16'd25, 4'd4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
